// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared state encoding, default widths and phase constants for the dds path
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      DONE
   } sweep_state_t;

   localparam int FWORD_W = 28;
   localparam int PWORD_W = 10;

   // quarter turn of a w-bit phase word, i.e. a 90 degree offset
   function automatic logic [31:0] quad_offset(input int w);
      return 32'd1 << (w - 2);
   endfunction

   localparam logic [PWORD_W-1:0] QUAD_OFFSET = PWORD_W'(quad_offset(PWORD_W));

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - sweep request/config and dds/measurement strobes (SWEEP_QUAD_EN adds quad_sel)
interface dds_sweep_ctrl_if
   import dds_pkg::*;
#(
   parameter int FW = FWORD_W,
   parameter int PW = PWORD_W,
   parameter int NW = 8,
   parameter int DW = 24
) ();

   logic          start;
   logic          abort;
   logic [FW-1:0] f_start;
   logic [FW-1:0] f_step;
   logic [NW-1:0] n_pts;
   logic [DW-1:0] dwell;
   logic [PW-1:0] pha_cfg;
   logic [FW-1:0] fre_w;
   logic [PW-1:0] pha_w;
   logic          busy;
   logic          meas_en;
   logic          meas_last;
   logic [NW-1:0] step_idx;
   logic          done;
`ifdef SWEEP_QUAD_EN
   logic          quad_sel;
`endif

   modport master (
      output start, abort, f_start, f_step, n_pts, dwell, pha_cfg,
      input  fre_w, pha_w, busy, meas_en, meas_last, step_idx, done
`ifdef SWEEP_QUAD_EN
      , input quad_sel
`endif
   );

   modport slave (
      input  start, abort, f_start, f_step, n_pts, dwell, pha_cfg,
      output fre_w, pha_w, busy, meas_en, meas_last, step_idx, done
`ifdef SWEEP_QUAD_EN
      , output quad_sel
`endif
   );

endinterface

// File: rtl/dds_sweep_ctrl_sweep_timer.sv
// rtl/dds_sweep_ctrl_sweep_timer.sv - loadable down-counter with zero flag for settle and dwell intervals
module sweep_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // load wins so the next interval can be armed on the cycle the current one expires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency sweep sequencer for the dds (SWEEP_QUAD_EN: two phase passes per point)
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int Fword_width = FWORD_W,
   parameter int Pword_width = PWORD_W,
   parameter int NSTEP_W     = 8,
   parameter int DWELL_W     = 24,
   parameter int SETTLE_CYC  = 64
) (
   input logic             clk,
   input logic             rst_n,
   dds_sweep_ctrl_if.slave bus
);

   // timer counts down to zero inclusive, so an interval of N cycles loads N-1
   localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYC - 1);

   sweep_state_t             state_q, state_nxt;
   logic [Fword_width-1:0]   fre_q, fre_nxt;
   logic [Pword_width-1:0]   pha_q, pha_nxt;
   logic [NSTEP_W-1:0]       idx_q, idx_nxt;
   logic [Fword_width-1:0]   fstep_q, fstep_nxt;
   logic [NSTEP_W-1:0]       npts_q, npts_nxt;
   logic [DWELL_W-1:0]       dwell_q, dwell_nxt;
`ifdef SWEEP_QUAD_EN
   localparam logic [Pword_width-1:0] QOFF = Pword_width'(quad_offset(Pword_width));
   logic [Pword_width-1:0]   pcfg_q, pcfg_nxt;
   logic                     quad_q, quad_nxt;
`endif

   logic                     tmr_load;
   logic [DWELL_W-1:0]       tmr_val;
   logic                     tmr_en;
   logic                     tmr_zero;
   logic [DWELL_W-1:0]       dwell_load;

   // dwell of zero still produces a single-cycle window
   assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

   sweep_timer #(.W(DWELL_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fre_q   <= '0;
         pha_q   <= '0;
         idx_q   <= '0;
         fstep_q <= '0;
         npts_q  <= '0;
         dwell_q <= '0;
`ifdef SWEEP_QUAD_EN
         pcfg_q  <= '0;
         quad_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_nxt;
         fre_q   <= fre_nxt;
         pha_q   <= pha_nxt;
         idx_q   <= idx_nxt;
         fstep_q <= fstep_nxt;
         npts_q  <= npts_nxt;
         dwell_q <= dwell_nxt;
`ifdef SWEEP_QUAD_EN
         pcfg_q  <= pcfg_nxt;
         quad_q  <= quad_nxt;
`endif
      end
   end

   // next-state, datapath updates and timer control; abort overrides everything outside IDLE
   always_comb begin
      state_nxt = state_q;
      fre_nxt   = fre_q;
      pha_nxt   = pha_q;
      idx_nxt   = idx_q;
      fstep_nxt = fstep_q;
      npts_nxt  = npts_q;
      dwell_nxt = dwell_q;
`ifdef SWEEP_QUAD_EN
      pcfg_nxt  = pcfg_q;
      quad_nxt  = quad_q;
`endif
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.n_pts != '0) begin
                  fstep_nxt = bus.f_step;
                  npts_nxt  = bus.n_pts;
                  dwell_nxt = bus.dwell;
                  fre_nxt   = bus.f_start;
                  pha_nxt   = bus.pha_cfg;
                  idx_nxt   = '0;
`ifdef SWEEP_QUAD_EN
                  pcfg_nxt  = bus.pha_cfg;
                  quad_nxt  = 1'b0;
`endif
                  tmr_load  = 1'b1;
                  tmr_val   = SETTLE_LOAD;
                  state_nxt = SETTLE;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         SETTLE: begin
            if (tmr_zero) begin
               tmr_load  = 1'b1;
               tmr_val   = dwell_load;
               state_nxt = MEASURE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         MEASURE: begin
            if (!tmr_zero) begin
               tmr_en = 1'b1;
            end else begin
`ifdef SWEEP_QUAD_EN
               if (!quad_q) begin
                  quad_nxt  = 1'b1;
                  pha_nxt   = pcfg_q + QOFF;
                  tmr_load  = 1'b1;
                  tmr_val   = SETTLE_LOAD;
                  state_nxt = SETTLE;
               end else begin
                  quad_nxt = 1'b0;
`endif
                  if (idx_q == npts_q - NSTEP_W'(1)) begin
                     state_nxt = DONE;
                  end else begin
                     fre_nxt   = fre_q + fstep_q;
                     idx_nxt   = idx_q + NSTEP_W'(1);
`ifdef SWEEP_QUAD_EN
                     pha_nxt   = pcfg_q;
`endif
                     tmr_load  = 1'b1;
                     tmr_val   = SETTLE_LOAD;
                     state_nxt = SETTLE;
                  end
`ifdef SWEEP_QUAD_EN
               end
`endif
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if ((state_q != IDLE) && bus.abort) begin
         state_nxt = IDLE;
         fre_nxt   = '0;
         idx_nxt   = '0;
         tmr_load  = 1'b0;
         tmr_en    = 1'b0;
`ifdef SWEEP_QUAD_EN
         quad_nxt  = 1'b0;
`endif
      end
   end

   assign bus.fre_w     = fre_q;
   assign bus.pha_w     = pha_q;
   assign bus.step_idx  = idx_q;
   assign bus.busy      = (state_q == SETTLE) || (state_q == MEASURE);
   assign bus.meas_en   = (state_q == MEASURE);
   assign bus.meas_last = (state_q == MEASURE) && tmr_zero;
   assign bus.done      = (state_q == DONE);
`ifdef SWEEP_QUAD_EN
   assign bus.quad_sel  = quad_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - scoreboard bench for dds_sweep_ctrl (SWEEP_QUAD_EN enables the quad pass test)
module tb_dds_sweep_ctrl;

   localparam int FW = 28;
   localparam int PW = 10;
   localparam int NW = 8;
   localparam int DW = 24;
   localparam int SETTLE = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dds_sweep_ctrl_if #(.FW(FW), .PW(PW), .NW(NW), .DW(DW)) bus ();

   dds_sweep_ctrl #(
      .Fword_width (FW),
      .Pword_width (PW),
      .NSTEP_W     (NW),
      .DWELL_W     (DW),
      .SETTLE_CYC  (SETTLE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          is_done;
      logic [FW-1:0] fre;
      logic [PW-1:0] pha;
      logic [NW-1:0] idx;
      int          len;
      bit          quad;
      bit          chk_gap;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   run_len = 0;
   int   settle_len = 0;
   int   last_win = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_win(input logic [FW-1:0] fre, input logic [NW-1:0] idx,
                           input logic [PW-1:0] pha, input int len, input bit quad);
      exp_t e;
      e.is_done = 1'b0; e.fre = fre; e.idx = idx; e.pha = pha;
      e.len = len; e.quad = quad; e.chk_gap = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_done(input logic [FW-1:0] fre, input bit chk_gap);
      exp_t e;
      e.is_done = 1'b1; e.fre = fre; e.idx = '0; e.pha = '0;
      e.len = 0; e.quad = 1'b0; e.chk_gap = chk_gap;
      sb.push_back(e);
   endtask

   // monitor: pops one expectation per measurement-window end or done pulse
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst_n) begin
         if (bus.meas_en) run_len++;
         else if (bus.busy) settle_len++;
         if (bus.meas_last) begin
            if (sb.size() == 0) begin
               chk("unexpected_window", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("win_kind", {31'd0, e.is_done}, 32'd0);
               chk("win_fre", 32'(bus.fre_w), 32'(e.fre));
               chk("win_idx", 32'(bus.step_idx), 32'(e.idx));
               chk("win_pha", 32'(bus.pha_w), 32'(e.pha));
               chk("win_len", 32'(run_len), 32'(e.len));
               chk("settle_len", 32'(settle_len), SETTLE);
`ifdef SWEEP_QUAD_EN
               chk("win_quad", {31'd0, bus.quad_sel}, {31'd0, e.quad});
`endif
            end
            run_len = 0;
            settle_len = 0;
            last_win = cyc;
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_kind", {31'd0, e.is_done}, 32'd1);
               chk("done_fre", 32'(bus.fre_w), 32'(e.fre));
               chk("done_busy", {31'd0, bus.busy}, 32'd0);
               if (e.chk_gap) chk("done_gap", 32'(cyc - last_win), 32'd1);
            end
         end
         if (!bus.busy) begin
            run_len = 0;
            settle_len = 0;
         end
      end
   end

   task automatic kick(input logic [FW-1:0] fs, input logic [FW-1:0] st, input logic [NW-1:0] n,
                       input logic [DW-1:0] dw, input logic [PW-1:0] ph);
      @(negedge clk);
      bus.f_start = fs; bus.f_step = st; bus.n_pts = n; bus.dwell = dw; bus.pha_cfg = ph;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || bus.busy || bus.done) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, {31'd0, n >= 3000}, 32'd0);
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic abort_at_pt1(input bit with_start, input string tag);
      int n = 0;
      while (!(bus.meas_en && bus.step_idx == 8'd1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_reach"}, {31'd0, n >= 1000}, 32'd0);
      @(negedge clk);
      bus.abort = 1'b1;
      bus.start = with_start;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk({tag, "_fre"}, 32'(bus.fre_w), 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_idx"}, 32'(bus.step_idx), 32'd0);
      chk({tag, "_meas"}, {31'd0, bus.meas_en}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      repeat (5) @(negedge clk);
      chk({tag, "_stay_idle"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.f_start = '0; bus.f_step = '0; bus.n_pts = '0; bus.dwell = '0; bus.pha_cfg = '0;
      repeat (3) @(negedge clk);
      chk("rst_fre", 32'(bus.fre_w), 32'd0);
      chk("rst_pha", 32'(bus.pha_w), 32'd0);
      chk("rst_flags", {28'd0, bus.busy, bus.meas_en, bus.meas_last, bus.done}, 32'd0);
      chk("rst_idx", 32'(bus.step_idx), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero-point sweep: straight to done, fre_w untouched
      push_done(28'h0, 1'b0);
      kick(28'h0100000, 28'h0010000, 8'd0, 24'd4, 10'h123);
      drain("npts0");
      chk("npts0_fre", 32'(bus.fre_w), 32'd0);

      // three-point sweep; inputs scrambled and start re-pulsed while busy
      push_win(28'h0100000, 8'd0, 10'h2A5, 4, 1'b0);
      push_win(28'h0110000, 8'd1, 10'h2A5, 4, 1'b0);
      push_win(28'h0120000, 8'd2, 10'h2A5, 4, 1'b0);
      push_done(28'h0120000, 1'b1);
      kick(28'h0100000, 28'h0010000, 8'd3, 24'd4, 10'h2A5);
      repeat (10) @(negedge clk);
      bus.f_start = 28'h5555555; bus.f_step = 28'h0ABCDEF; bus.n_pts = 8'd9;
      bus.dwell = 24'd17; bus.pha_cfg = 10'h0F0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain("sweep3");
      chk("sweep3_busy", {31'd0, bus.busy}, 32'd0);

      // dwell of zero gives a single-cycle window
      push_win(28'h0ABCDEF, 8'd0, 10'h155, 1, 1'b0);
      push_done(28'h0ABCDEF, 1'b1);
      kick(28'h0ABCDEF, 28'h0000001, 8'd1, 24'd0, 10'h155);
      drain("dwell0");

      // frequency wrap modulo 2^28
      push_win(28'hFFFFFF0, 8'd0, 10'h001, 2, 1'b0);
      push_win(28'h0000010, 8'd1, 10'h001, 2, 1'b0);
      push_done(28'h0000010, 1'b1);
      kick(28'hFFFFFF0, 28'h0000020, 8'd2, 24'd2, 10'h001);
      drain("wrap");

      // abort while idle changes nothing
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_fre", 32'(bus.fre_w), 32'h0000010);
      chk("idle_abort_busy", {31'd0, bus.busy}, 32'd0);

      // abort in second measure cycle of point 1
      push_win(28'h0100000, 8'd0, 10'h2A5, 4, 1'b0);
      kick(28'h0100000, 28'h0010000, 8'd3, 24'd4, 10'h2A5);
      abort_at_pt1(1'b0, "abort");

      // same, with start asserted together with abort
      push_win(28'h0300000, 8'd0, 10'h011, 4, 1'b0);
      kick(28'h0300000, 28'h0010000, 8'd3, 24'd4, 10'h011);
      abort_at_pt1(1'b1, "abort_start");

`ifdef SWEEP_QUAD_EN
      // two phase passes on a single point, second pass offset by a quarter turn
      push_win(28'h0200000, 8'd0, 10'h3F0, 3, 1'b0);
      push_win(28'h0200000, 8'd0, 10'h0F0, 3, 1'b1);
      push_done(28'h0200000, 1'b1);
      kick(28'h0200000, 28'h0010000, 8'd1, 24'd3, 10'h3F0);
      drain("quad");
`endif

      // asynchronous reset mid-sweep
      kick(28'h0400000, 28'h0010000, 8'd2, 24'd4, 10'h077);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_fre", 32'(bus.fre_w), 32'd0);
      chk("midrst_pha", 32'(bus.pha_w), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_idle", {31'd0, bus.busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
